// File: rtl/pixel_drain.sv
// pixel_drain: drains completed ping-pong RAM halves into a pixel stream; define PIX16_EN for 16-bit pixels
module pixel_drain #(
    parameter int WORDS_PER_LINE  = 348,
    parameter int LINES_PER_FRAME = 1024,
    parameter int HDR_WORDS       = 0
) (
    input  logic        RFCLK,
    input  logic        nRST_Pixel,
    input  logic        wr_bank,
    input  logic        MODE_SET,
    input  logic        frame_sync,
    input  logic [31:0] rddata,
    output logic [9:0]  rdaddr,
    output logic        rden,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done,
    output logic [9:0]  line_cnt,
    output logic        overrun,
    output logic [7:0]  cmd_skip_cnt,
    output logic        busy
);
`ifdef PIX16_EN
    localparam int SW = 1;
`else
    localparam int SW = 2;
`endif
    localparam logic [8:0] HDR_W  = 9'(HDR_WORDS);
    localparam logic [8:0] LAST_W = 9'(HDR_WORDS + WORDS_PER_LINE - 1);
    localparam logic [9:0] LAST_L = 10'(LINES_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, EMIT} state_t;
    state_t state, state_nxt;

    logic          bank_prev, rdbank, sof_pend, sof_line, sof_go;
    logic [8:0]    widx;
    logic [31:0]   shreg;
    logic [SW-1:0] sub_idx;
    logic          done_evt, start, accept, last_word, last_pix, line_end, frame_end;

    assign done_evt  = wr_bank ^ bank_prev;
    assign start     = done_evt && !MODE_SET;
    // a completed half while draining aborts the current pixel, so it can never be accepted
    assign accept    = state == EMIT && pix_ready && !done_evt;
    assign last_word = widx == LAST_W;
    assign last_pix  = last_word && &sub_idx;
    assign line_end  = accept && last_pix;
    assign frame_end = line_end && line_cnt == LAST_L;
    assign sof_go    = sof_line || sof_pend || frame_sync;

    always_comb begin
        state_nxt = done_evt ? (MODE_SET ? IDLE : FETCH) :
                    state == FETCH ? WAIT :
                    state == WAIT ? EMIT :
                    accept && &sub_idx ? (last_word ? IDLE : FETCH) : state;
    end

    assign rden      = state == FETCH;
    assign rdaddr    = rden ? {rdbank, widx} : 10'd0;
    assign pix_valid = state == EMIT;
    assign pix_sof   = pix_valid && sof_line;
    assign pix_eol   = pix_valid && last_pix;
    assign busy      = state != IDLE;
`ifdef PIX16_EN
    assign pix_data  = sub_idx[0] ? shreg[31:16] : shreg[15:0];
`else
    assign pix_data  = {8'h00, shreg[{sub_idx, 3'b000} +: 8]};
`endif

    always_ff @(posedge RFCLK or negedge nRST_Pixel) begin
        if (!nRST_Pixel) begin
            state        <= IDLE;
            bank_prev    <= 1'b0;
            rdbank       <= 1'b0;
            sof_pend     <= 1'b0;
            sof_line     <= 1'b0;
            widx         <= '0;
            shreg        <= '0;
            sub_idx      <= '0;
            line_cnt     <= '0;
            overrun      <= 1'b0;
            cmd_skip_cnt <= '0;
            frame_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            bank_prev  <= wr_bank;
            frame_done <= frame_end;
            overrun    <= overrun | (done_evt & busy);
            sof_pend   <= start ? 1'b0 : sof_pend | frame_sync;
            if (done_evt && MODE_SET) cmd_skip_cnt <= cmd_skip_cnt + 8'd1;
            if (start) begin
                rdbank   <= bank_prev;
                widx     <= HDR_W;
                sof_line <= sof_go;
                if (sof_go) line_cnt <= '0;
            end
            if (state == WAIT) begin
                shreg   <= rddata;
                sub_idx <= '0;
            end
            if (accept) begin
                sof_line <= 1'b0;
                sub_idx  <= sub_idx + SW'(1);
                if (&sub_idx && !last_word) widx <= widx + 9'd1;
                if (line_end) line_cnt <= frame_end ? 10'd0 : line_cnt + 10'd1;
            end
        end
    end
endmodule

// File: doc/pixel_drain.md
Name: pixel_drain

Overview:
- Downstream consumer of the ingress parser's ping-pong packet RAM.
- Detects each completed half (one 1408-byte data packet = one image line), reads it back through the RAM read port, and unpacks 32-bit words into a pixel stream with valid/ready handshake.
- Generates start-of-frame, end-of-line and frame-done markers for the frame store.
- Discards command packets (MODE_SET=1).

Parameters:
- WORDS_PER_LINE, 348, 32-bit pixel words per packet half (1392 pixels × 8 bit / 32).
- LINES_PER_FRAME, 1024, lines per picture.
- HDR_WORDS, 0, leading words in each half to skip before pixel data.

Ports:
- RFCLK  in  1  clock.
- nRST_Pixel  in  1  asynchronous active-low reset.
- wr_bank  in  1  ingress wraddr[9]; a toggle marks a completed half.
- MODE_SET  in  1  ingress mode; 1 = completed half is a command packet.
- frame_sync  in  1  ingress one-cycle start-of-picture pulse.
- rddata  in  32  RAM read data; valid exactly 1 cycle after rden.
- rdaddr  out  10  RAM read address; bit 9 = bank being drained.
- rden  out  1  RAM read enable.
- pix_data  out  16  pixel; 8-bit mode zero-extended.
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  downstream accept.
- pix_sof  out  1  first pixel of a frame, qualified by pix_valid.
- pix_eol  out  1  last pixel of a line, qualified by pix_valid.
- frame_done  out  1  one-cycle pulse after the eol of the last line.
- line_cnt  out  10  current line index.
- overrun  out  1  sticky; set when a new half completes while draining.
- cmd_skip_cnt  out  8  wrapping count of discarded command halves.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, bank_prev <= 0, sof_pend <= 0.
- Toggle detect: bank_prev registers wr_bank. done_evt = wr_bank ^ bank_prev, and the completed bank is bank_prev. MODE_SET is sampled in the same cycle as done_evt.
- frame_sync:
  - Sets sof_pend.
  - The first pixel of the next drained line asserts pix_sof; line_cnt <= 0 at that line start; sof_pend is then cleared.
- States: IDLE, FETCH, WAIT, EMIT.
  - IDLE:
    - done_evt with MODE_SET=1: cmd_skip_cnt+1, stay in IDLE.
    - done_evt with MODE_SET=0: rdbank <= bank_prev, widx <= HDR_WORDS, go to FETCH.
  - FETCH: rden=1, rdaddr={rdbank, widx[8:0]}, go to WAIT.
  - WAIT: capture rddata into shreg, byte_idx <= 0, go to EMIT.
  - EMIT:
    - pix_valid=1, pix_data={8'h00, shreg[8*byte_idx+7 -: 8]} (byte 0 = bits 7:0 first).
    - pix_valid stays high and pix_data stays stable until pix_ready is high.
    - On accept at byte_idx=3:
      - If widx=HDR_WORDS+WORDS_PER_LINE-1: pix_eol asserted on that pixel. Then line_cnt+1, or on line_cnt=LINES_PER_FRAME-1: line_cnt <= 0 and frame_done pulses next cycle. Go to IDLE.
      - Otherwise widx+1, go to FETCH.
- Throughput: a 2-cycle bubble per word (FETCH, WAIT). The line drain takes ≤ 6·348 cycles with pix_ready=1, which is shorter than the ingress fill time.
- Overrun: done_evt while not IDLE means the writer is now filling the bank being drained.
  - overrun <= 1 (sticky until reset).
  - Current line aborted immediately with no eol; the partial line does not increment line_cnt.
  - If MODE_SET=0, the drain restarts on the newly completed bank in FETCH the next cycle; otherwise the block returns to IDLE and cmd_skip_cnt increments.
- frame_sync and done_evt in the same cycle: both take effect; the started line carries pix_sof.
- widx is 9 bits; HDR_WORDS+WORDS_PER_LINE ≤ 512 is required, and the halves are never crossed.
- Asynchronous reset mid-line: all state cleared immediately, no pending pixels retained.

Optional Feature:
- PIX16_EN: defined means 16-bit pixels.
  - Two pixels per word; pix_data = shreg[15:0], then shreg[31:16].
  - byte_idx becomes a 1-bit half index; eol on the second half of the last word.
  - Line pixel count = 2·WORDS_PER_LINE.
- Undefined: 8-bit mode as above.

Test Plan:
- Reset, toggle wr_bank 0→1 with MODE_SET=0, RAM bank0 word n = n, pix_ready=1 → 1392 pixels starting 0x00,0x00,0x00,0x00,0x01…; eol on pixel 1391; line_cnt=1; rdaddr range 0x000–0x15B.
- frame_sync pulse, then toggle 1→0 → first pixel has pix_sof=1, line_cnt=0 after the reset-to-0 then becomes 1, rdaddr starts 0x200.
- Toggle with MODE_SET=1 → no rden, no pix_valid, cmd_skip_cnt=1.
- pix_ready=0 for 5 cycles on pixel 2 → pix_data and pix_valid held stable, no extra rden, pixel order unchanged.
- Second toggle after 100 pixels of a line → overrun=1, line aborted without eol, new drain starts at rdaddr {new bank, 0}, line_cnt unchanged.
- Drain 1024 lines with LINES_PER_FRAME=1024 → frame_done pulses once one cycle after the final eol; line_cnt=0.
